apb_req_arbiter: RTL
====================

Name: apb_req_arbiter

Overview:
- Shares one APB requester bridge (local interface: bus_ena / a_code / bus_addr / bus_wdata in; bus_wait / bus_rdata / bus_slverr out) between NUM_REQ local masters.
- Round-robin arbitration; one transaction in flight at a time.
- Sits between the CPU/DMA-side requesters and the bridge's local port. Sequences the bridge with a single-cycle bus_ena pulse per grant and returns the result to the granted requester only.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
START_TIMEOUT, 4, cycles to wait for bus_wait to rise after issue before flagging an error

Ports:
pclk  in  1  clock
presetn  in  1  async active-low reset
req_valid  in  NUM_REQ  per-requester request, held until rsp_done
req_code  in  NUM_REQ*3  per-requester opcode: 0 put-full, 1 put-partial, 4 get; slice i = [3i+2:3i]
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, flattened
req_wdata  in  NUM_REQ*DATA_WIDTH  per-requester write data, flattened
rsp_done  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid while rsp_done != 0
rsp_slverr  out  1  error, valid while rsp_done != 0
grant_idx  out  $clog2(NUM_REQ)  current/last granted index (debug)
busy  out  1  transaction in flight
bus_ena  out  1  to bridge
a_code  out  3  to bridge
bus_addr  out  ADDR_WIDTH  to bridge
bus_wdata  out  DATA_WIDTH  to bridge
bus_wait  in  1  from bridge
bus_rdata  in  DATA_WIDTH  from bridge
bus_slverr  in  1  from bridge

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous, active-low (presetn).
- Reset values: all outputs registered; all 0 at reset. State is S_IDLE. RR pointer last = NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-transaction: abandon immediately and return to S_IDLE; no rsp_done is emitted.
- FSM states:
  - S_IDLE: if any req_valid, pick winner = first set bit searching from last+1 with wrap. Register grant_idx and the winner's code/addr/wdata onto a_code/bus_addr/bus_wdata. Go to S_ISSUE.
  - S_ISSUE: bus_ena=1 for exactly this cycle; busy=1; clear the timeout counter. Go to S_START.
  - S_START: bus_ena=0.
    - bus_wait==1 → S_BUSY.
    - Otherwise increment the counter. When it reaches START_TIMEOUT, capture rsp_rdata=0 and rsp_slverr=1, then go to S_DONE.
  - S_BUSY: when bus_wait==0, capture rsp_rdata<=bus_rdata and rsp_slverr<=bus_slverr. Go to S_DONE.
  - S_DONE: rsp_done[grant_idx]=1 for this cycle only; last<=grant_idx; busy=0. Go to S_IDLE.
- Payload stability: a_code/bus_addr/bus_wdata are held from S_IDLE exit through S_DONE. They are not cleared afterwards.
- rsp_rdata capture: captured for every opcode, including writes. Requesters ignore it on writes.
- rsp_rdata/rsp_slverr hold until the next capture.
- Requester rule:
  - Keep req_valid and payload stable from assertion until the rsp_done pulse.
  - req_valid still high in the cycle after rsp_done = a new request with the payload present then.
  - Dropping req_valid before rsp_done is illegal; the in-flight transaction still completes and still pulses rsp_done.
- Arbiter latency (empty arbiter): req_valid sampled high at edge N → bus_ena high in cycle N+2. rsp_done occurs 2 cycles after the cycle bus_wait is sampled low in S_BUSY.
- Issue gating: only one bus_ena per transaction. bus_ena is never asserted while bus_wait=1, so the bridge never takes its back-to-back path.
- Fairness: a continuously requesting master is granted at most once per NUM_REQ grants when all request.
- Simultaneous events: requests arriving during S_ISSUE..S_DONE wait. A request from the master just completed (S_DONE) loses to any other pending requester.
- Opcodes pass through unchanged; no checking.

Decomposition:
- Shared package apb_pkg:
  - opcode typedef/constants: PUT_FULL_DATA=0, PUT_PARTIAL_DATA=1, GET=4.
  - arbiter state enum: S_IDLE, S_ISSUE, S_START, S_BUSY, S_DONE.
- Sub-module rr_pick: combinational round-robin picker; inputs request vector and last pointer; outputs valid and index. Reusable by other shared-resource controllers.

Test Plan:
- Single read:
  - req_valid=0001, code=4, addr=0x100. Bridge model asserts bus_wait the cycle after bus_ena, drops it 3 cycles later with rdata=0xDEADBEEF, slverr=0.
  - Required: one bus_ena pulse with a_code=4, bus_addr=0x100; rsp_done=0001 once; rsp_rdata=0xDEADBEEF; rsp_slverr=0.
- All four request at once, writes with wdata=0x10*i:
  - Required: grant order 0,1,2,3; exactly 4 bus_ena pulses, never overlapping bus_wait=1; each rsp_done one-hot in order.
- Fairness:
  - Requesters 0 and 2 each hold valid and re-request immediately after each done.
  - Required: grants alternate 0,2,0,2 over 8 transactions.
- Slave error:
  - Requester 1 write, bridge returns bus_slverr=1.
  - Required: rsp_done=0010, rsp_slverr=1. The next transaction (requester 3) returns rsp_slverr=0.
- Timeout:
  - Bridge model never raises bus_wait.
  - Required: rsp_done pulses with rsp_slverr=1, rsp_rdata=0, START_TIMEOUT+2 cycles after bus_ena; arbiter back in S_IDLE.
- Reset mid-operation:
  - Deassert presetn during S_BUSY.
  - Required: all outputs 0 immediately (asynchronous); no rsp_done. After release with req_valid=0100, requester 2 is granted first.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester-side blocks: opcode encodings and
// the arbiter state machine encoding.
package apb_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    GET              = 3'd4
  } apb_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_START,
    S_BUSY,
    S_DONE
  } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward from last+1 with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int unsigned cand;

  // Walk the candidates in priority order; the first hit wins and later hits are ignored.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB requester bridge between NUM_REQ local
// masters, with one transaction in flight and a start-of-transfer timeout.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int START_TIMEOUT = 4
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_code,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_done,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_slverr,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic                          busy,
  output logic                          bus_ena,
  output logic [OP_WIDTH-1:0]           a_code,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [DATA_WIDTH-1:0]         bus_wdata,
  input  logic                          bus_wait,
  input  logic [DATA_WIDTH-1:0]         bus_rdata,
  input  logic                          bus_slverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

  arb_state_e          state;
  logic [IDX_W-1:0]    last;
  logic [CNT_W-1:0]    start_cnt;
  logic [NUM_REQ-1:0]  req_eligible;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

  // The requester being acknowledged this cycle still shows req_valid; mask it so
  // its held request is not mistaken for a new one.
  assign req_eligible = req_valid & ~rsp_done;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req   (req_eligible),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= S_IDLE;
      last       <= IDX_W'(NUM_REQ - 1);
      start_cnt  <= '0;
      grant_idx  <= '0;
      a_code     <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_ena    <= 1'b0;
      busy       <= 1'b0;
      rsp_done   <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      bus_ena  <= 1'b0;
      rsp_done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant_idx <= pick_idx;
            a_code    <= req_code[OP_WIDTH*pick_idx +: OP_WIDTH];
            bus_addr  <= req_addr[ADDR_WIDTH*pick_idx +: ADDR_WIDTH];
            bus_wdata <= req_wdata[DATA_WIDTH*pick_idx +: DATA_WIDTH];
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus_ena   <= 1'b1;
          busy      <= 1'b1;
          start_cnt <= '0;
          state     <= S_START;
        end
        S_START: begin
          if (bus_wait) begin
            state <= S_BUSY;
          end else if (start_cnt == CNT_W'(START_TIMEOUT)) begin
            // Bridge never acknowledged the issue: complete with an error.
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b1;
            state      <= S_DONE;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          if (!bus_wait) begin
            rsp_rdata  <= bus_rdata;
            rsp_slverr <= bus_slverr;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_done[grant_idx] <= 1'b1;
          last                <= grant_idx;
          busy                <= 1'b0;
          state               <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
